mdr_req_sequencer: RTL and testbench

Host-side initiator for the multiply/divide/root (MDR) units. It accepts one operation request over a valid/ready handshake and screens it for divide-by-zero and illegal opcodes. It drives the unit's one-cycle `start` pulse, waits for the unit's `ready` pulse under a timeout, then presents the captured result on an output valid/ready handshake. It sits between the bus/host logic and the MDR control units: it generates the `start` that a control unit samples, and consumes the `ready` that the control unit raises.

---
 rtl/mdr_pkg.sv | 31 +++
 rtl/mdr_req_sequencer_if.sv | 44 ++++
 rtl/mdr_timeout_counter.sv | 37 +++
 rtl/mdr_req_sequencer.sv | 133 +++++++++++++
 tb/tb_mdr_req_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdr_pkg.sv
// Shared types for the MDR host-side request path: opcodes, response error
// codes and the request sequencer state encoding.
package mdr_pkg;

    typedef enum logic [1:0] {
        MUL     = 2'b00,
        DIV     = 2'b01,
        SQRT    = 2'b10,
        ILLEGAL = 2'b11
    } mdr_op_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_DIV0    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ILLEGAL = 2'b11
    } mdr_err_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        HOLD   = 2'b11
    } mdr_seq_state_t;

    // Requests that are answered locally and never reach the MDR unit.
    function automatic logic is_screened(input mdr_op_t op, input logic b_is_zero);
        return (op == ILLEGAL) || ((op == DIV) && b_is_zero);
    endfunction

endpackage

// File: rtl/mdr_req_sequencer_if.sv
// Bundle of the request, MDR-unit and response handshakes around the sequencer.
// master = the sequencer itself, slave = the surrounding host/unit logic.
interface mdr_req_sequencer_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;

    logic          mdr_start;
    logic [1:0]    mdr_op;
    logic [DW-1:0] mdr_a;
    logic [DW-1:0] mdr_b;
    logic          mdr_ready;
    logic [DW-1:0] mdr_result;
    logic [DW-1:0] mdr_remainder;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_remainder;
    logic [1:0]    out_err;

    modport master (
        input  in_valid, in_op, in_a, in_b,
        output in_ready,
        output mdr_start, mdr_op, mdr_a, mdr_b,
        input  mdr_ready, mdr_result, mdr_remainder,
        output out_valid, out_result, out_remainder, out_err,
        input  out_ready
    );

    modport slave (
        output in_valid, in_op, in_a, in_b,
        input  in_ready,
        input  mdr_start, mdr_op, mdr_a, mdr_b,
        output mdr_ready, mdr_result, mdr_remainder,
        input  out_valid, out_result, out_remainder, out_err,
        output out_ready
    );

endinterface

// File: rtl/mdr_timeout_counter.sv
// WAIT-phase cycle counter; expired flags the last permitted WAIT cycle.
// One spare bit means the count can never wrap back into range.
module mdr_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_req_sequencer.sv
// Host-side initiator for the MDR units: screens a request, launches the unit,
// waits for completion under a timeout and holds the response until taken.
module mdr_req_sequencer
    import mdr_pkg::*;
#(
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 rst,
    mdr_req_sequencer_if.master bus
);

    mdr_seq_state_t state_q, state_d;
    mdr_op_t        op_q, op_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [DW-1:0]  res_q, res_d;
    logic [DW-1:0]  rem_q, rem_d;
    mdr_err_t       err_q, err_d;

    logic cnt_clr;
    logic cnt_en;
    logic expired;

    // Clearing during LAUNCH makes the first WAIT cycle count zero.
    assign cnt_clr = (state_q == LAUNCH);
    assign cnt_en  = (state_q == WAIT);

    mdr_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        rem_d   = rem_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d = mdr_op_t'(bus.in_op);
                    a_d  = bus.in_a;
                    b_d  = bus.in_b;
                    if (is_screened(mdr_op_t'(bus.in_op), bus.in_b == '0)) begin
                        state_d = HOLD;
                        if (mdr_op_t'(bus.in_op) == ILLEGAL) begin
                            res_d = '0;
                            rem_d = '0;
                            err_d = ERR_ILLEGAL;
                        end else begin
                            res_d = '1;
                            rem_d = bus.in_a;
                            err_d = ERR_DIV0;
                        end
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end

            LAUNCH: begin
                state_d = WAIT;
            end

            WAIT: begin
                // A completion in the expiry cycle still counts as a completion.
                if (bus.mdr_ready) begin
                    state_d = HOLD;
                    res_d   = bus.mdr_result;
                    rem_d   = bus.mdr_remainder;
                    err_d   = ERR_OK;
                end else if (expired) begin
                    state_d = HOLD;
                    res_d   = '0;
                    rem_d   = '0;
                    err_d   = ERR_TIMEOUT;
                end
            end

            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= MUL;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.mdr_start     = (state_q == LAUNCH);
    assign bus.mdr_op        = op_q;
    assign bus.mdr_a         = a_q;
    assign bus.mdr_b         = b_q;
    assign bus.out_valid     = (state_q == HOLD);
    assign bus.out_result    = res_q;
    assign bus.out_remainder = rem_q;
    assign bus.out_err       = err_q;

endmodule

// File: tb/tb_mdr_req_sequencer.sv
// Bench for mdr_req_sequencer: table of requests against a behavioural MDR
// responder, scoreboarded responses, plus reset-during-WAIT handling.
module tb_mdr_req_sequencer;
    import mdr_pkg::*;

    localparam int DW      = 16;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mdr_req_sequencer_if #(.DW(DW)) bus ();

    mdr_req_sequencer #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            delay;   // responder latency after start; -1 = silent
        int            hold;    // cycles of out_ready low once out_valid rises
        logic [DW-1:0] res;
        logic [DW-1:0] rem;
        logic [1:0]    err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] res;
        logic [DW-1:0] rem;
        logic [1:0]    err;
    } exp_t;

    vec_t vecs[10];
    vec_t v_after;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int resp_delay = -1;
    int stray_req  = 0;
    int start_cnt  = 0;
    int start_cyc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural MDR unit: answers resp_delay cycles after each start pulse.
    initial begin : responder
        int                countdown;
        int                stray_done;
        int                r;
        logic [2*DW-1:0]   prod;
        logic [DW-1:0]     r_res, r_rem;
        countdown  = -1;
        stray_done = 0;
        r_res      = '0;
        r_rem      = '0;
        bus.mdr_ready     = 1'b0;
        bus.mdr_result    = 16'hDEAD;
        bus.mdr_remainder = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            bus.mdr_ready     = 1'b0;
            bus.mdr_result    = 16'hDEAD;
            bus.mdr_remainder = 16'hDEAD;
            if (!rst) countdown = -1;
            if (bus.mdr_start) begin
                start_cnt++;
                start_cyc = cyc_cnt;
                case (bus.mdr_op)
                    2'b00: begin
                        prod  = (2*DW)'(bus.mdr_a) * (2*DW)'(bus.mdr_b);
                        r_res = prod[DW-1:0];
                        r_rem = prod[2*DW-1:DW];
                    end
                    2'b01: begin
                        r_res = bus.mdr_a / bus.mdr_b;
                        r_rem = bus.mdr_a % bus.mdr_b;
                    end
                    2'b10: begin
                        r = 0;
                        while ((r + 1) * (r + 1) <= int'(bus.mdr_a)) r++;
                        r_res = DW'(r);
                        r_rem = bus.mdr_a - DW'(r * r);
                    end
                    default: begin
                        r_res = '0;
                        r_rem = '0;
                    end
                endcase
                countdown = resp_delay;
            end else if (countdown > 0) begin
                countdown--;
            end
            if (countdown == 0) begin
                bus.mdr_ready     = 1'b1;
                bus.mdr_result    = r_res;
                bus.mdr_remainder = r_rem;
                countdown         = -1;
            end else if (stray_req != stray_done) begin
                stray_done        = stray_req;
                bus.mdr_ready     = 1'b1;
                bus.mdr_result    = 16'hBEEF;
                bus.mdr_remainder = 16'hBEEF;
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int            sc0;
        int            waited;
        int            vcyc;
        bit            screened;
        exp_t          e;
        logic [DW-1:0] hr, hm;
        logic [1:0]    he;

        screened   = (v.op == 2'b11) || ((v.op == 2'b01) && (v.b == '0));
        resp_delay = v.delay;
        sc0        = start_cnt;

        bus.in_op     = v.op;
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        check($sformatf("v%0d in_ready before accept", idx), bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        e.res = v.res;
        e.rem = v.rem;
        e.err = v.err;
        sb.push_back(e);

        check($sformatf("v%0d mdr_start after accept", idx), bus.mdr_start, screened ? 0 : 1);
        check($sformatf("v%0d in_ready busy", idx), bus.in_ready, 0);
        check($sformatf("v%0d captured op/a/b", idx), {bus.mdr_op, bus.mdr_a, bus.mdr_b}, {v.op, v.a, v.b});

        waited = 0;
        while (!bus.out_valid && waited < TIMEOUT + 20) begin
            tick();
            waited++;
        end
        check($sformatf("v%0d out_valid seen", idx), bus.out_valid, 1);
        vcyc = cyc_cnt;
        if (screened)
            check($sformatf("v%0d screened latency", idx), waited, 0);
        else if (v.delay < 0 || v.delay > TIMEOUT)
            check($sformatf("v%0d timeout latency", idx), vcyc, start_cyc + TIMEOUT + 1);
        else
            check($sformatf("v%0d completion latency", idx), vcyc, start_cyc + v.delay + 1);

        hr = bus.out_result;
        hm = bus.out_remainder;
        he = bus.out_err;
        if (v.hold > 0) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 2'b11;
            bus.in_a     = 16'h7777;
            bus.in_b     = '0;
            for (int i = 0; i < v.hold; i++) begin
                if (i == 3) stray_req++;
                tick();
                check($sformatf("v%0d hold stable c%0d", idx, i),
                      {bus.out_valid, bus.out_result, bus.out_remainder, bus.out_err},
                      {1'b1, hr, hm, he});
                check($sformatf("v%0d in_ready in hold c%0d", idx, i), bus.in_ready, 0);
            end
        end

        bus.out_ready = 1'b1;
        e = sb.pop_front();
        check($sformatf("v%0d out_result", idx), bus.out_result, e.res);
        check($sformatf("v%0d out_remainder", idx), bus.out_remainder, e.rem);
        check($sformatf("v%0d out_err", idx), bus.out_err, e.err);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check($sformatf("v%0d in_ready after handshake", idx), {bus.in_ready, bus.out_valid}, 2'b10);
        check($sformatf("v%0d start pulses", idx), start_cnt - sc0, screened ? 0 : 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        //         op     a         b         dly  hold res       rem       err
        vecs[0] = '{2'b01, 16'd100,  16'd7,    20,  10,  16'd14,   16'd2,    2'b00};
        vecs[1] = '{2'b01, 16'h1234, 16'h0000, -1,  0,   16'hFFFF, 16'h1234, 2'b01};
        vecs[2] = '{2'b00, 16'd300,  16'd500,  5,   0,   16'h49F0, 16'h0002, 2'b00};
        vecs[3] = '{2'b10, 16'd144,  16'h5555, 3,   2,   16'd12,   16'd0,    2'b00};
        vecs[4] = '{2'b11, 16'd5,    16'd0,    -1,  3,   16'd0,    16'd0,    2'b11};
        vecs[5] = '{2'b00, 16'd1000, 16'd1000, -1,  0,   16'd0,    16'd0,    2'b10};
        vecs[6] = '{2'b00, 16'd7,    16'd9,    64,  0,   16'd63,   16'd0,    2'b00};
        vecs[7] = '{2'b01, 16'hFFFF, 16'h0010, 1,   0,   16'h0FFF, 16'h000F, 2'b00};
        vecs[8] = '{2'b10, 16'd200,  16'd0,    2,   0,   16'd14,   16'd4,    2'b00};
        vecs[9] = '{2'b01, 16'd0,    16'd0,    -1,  0,   16'hFFFF, 16'd0,    2'b01};
        v_after = '{2'b10, 16'd144,  16'd0,    4,   0,   16'd12,   16'd0,    2'b00};

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready/start/out_valid", {bus.in_ready, bus.mdr_start, bus.out_valid}, 3'b100);
        check("reset out data/err", {bus.out_result, bus.out_remainder, bus.out_err}, '0);
        check("reset mdr regs", {bus.mdr_op, bus.mdr_a, bus.mdr_b}, '0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset while the unit is being waited on.
        resp_delay   = -1;
        bus.in_op    = 2'b00;
        bus.in_a     = 16'd3;
        bus.in_b     = 16'd4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid-WAIT busy", {bus.in_ready, bus.mdr_start, bus.out_valid}, 3'b000);
        rst = 1'b0;
        #1;
        check("async reset in_ready/out_valid", {bus.in_ready, bus.out_valid}, 2'b10);
        tick();
        rst = 1'b1;
        tick();
        check("after reset release", {bus.in_ready, bus.out_valid, bus.mdr_start, bus.out_err}, 5'b10000);
        check("after reset out data", {bus.out_result, bus.out_remainder}, '0);

        run_vec(10, v_after);
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
